// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one I2C master, sequencing
// the control-word write and tracking master busy to report completion status.
module i2c_arbiter #(
  parameter int NREQ          = 4,
  parameter int ISSUE_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_ctrl,
  input  logic [NREQ-1:0]      req_read,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [31:0]          rsp_status,
  output logic                 rsp_err,
  output logic [31:0]          m_ctrl_data,
  output logic                 m_wr_ctrl,
  output logic                 m_read,
  input  logic [31:0]          m_status
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(ISSUE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitReady,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StRespond
  } state_e;

  state_e          r_state;
  logic [IW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [31:0]     r_status;
  logic            r_err;
  logic [31:0]     r_ctrl;
  logic            r_wr_ctrl;
  logic            r_read;

  logic            w_busy;
  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_cand;
  int              w_c;
  logic [NREQ-1:0] w_onehot;
  logic [31:0]     w_ctrl;
  logic            w_rd;

  assign w_busy = m_status[31];

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_c     = 0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_c    = (int'(r_last) + k) % NREQ;
      w_cand = IW'(w_c);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    w_ctrl   = '0;
    w_rd     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IW'(i)) begin
        w_onehot[i] = 1'b1;
        w_ctrl      = req_ctrl[32*i +: 32];
        w_rd        = req_read[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_last    <= IW'(NREQ - 1);
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_status  <= '0;
      r_err     <= 1'b0;
      r_ctrl    <= '0;
      r_wr_ctrl <= 1'b0;
      r_read    <= 1'b0;
    end else begin
      r_wr_ctrl <= 1'b0;
      r_done    <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_gnt   <= w_onehot;
            r_last  <= w_win;
            r_ctrl  <= w_ctrl;
            r_read  <= w_rd;
            r_state <= StWaitReady;
          end
        end
        StWaitReady: begin
          // Strobe is only raised after busy was seen low, so it never overlaps busy.
          if (!w_busy) begin
            r_wr_ctrl <= 1'b1;
            r_state   <= StIssue;
          end
        end
        StIssue: begin
          r_cnt   <= CW'(ISSUE_TIMEOUT);
          r_state <= StWaitBusy;
        end
        StWaitBusy: begin
          if (w_busy) begin
            r_state <= StWaitDone;
          end else begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt <= CW'(1)) begin
              r_err    <= 1'b1;
              r_status <= m_status;
              r_done   <= r_gnt;
              r_gnt    <= '0;
              r_state  <= StRespond;
            end
          end
        end
        StWaitDone: begin
          if (!w_busy) begin
            r_err    <= 1'b0;
            r_status <= m_status;
            r_done   <= r_gnt;
            r_gnt    <= '0;
            r_state  <= StRespond;
          end
        end
        StRespond: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign rsp_status  = r_status;
  assign rsp_err     = r_err;
  assign m_ctrl_data = r_ctrl;
  assign m_wr_ctrl   = r_wr_ctrl;
  assign m_read      = r_read;

endmodule
